// File: rtl/reg_dump_tx.sv
// reg_dump_tx: transmit side of the architectural-state observation path.
//
// On dump_req (sampled while idle) the block freezes the pipeline, sends the
// latched PC as a header word, then walks $s0-$s7 (and $t0-$t3 when
// INCLUDE_T=1) through the register file's combinational debug read port.
// Each register is fetched in one cycle and offered on the stream in the next.
//
// Optional feature: define REG_DUMP_CHECKSUM_EN to append an XOR checksum word
// (tag 6'h3F) after the last register. In that build the checksum word carries
// out_last instead of the last register word.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   dump_req         frame request, only honoured while idle
//   pc_in            current PC, latched on the request edge
//   stall_req        pipeline freeze request, high while busy
//   dbg_rd_addr      debug read address, non-zero only while fetching
//   dbg_rd_data      debug read data, valid in the same cycle
//   out_valid/ready  stream handshake
//   out_data         stream word
//   out_tag          6'h20 PC header, {1'b0,regaddr} register, 6'h3F checksum
//   out_last         final word of the frame
//   busy             high in any state except idle
module reg_dump_tx #(
  parameter int unsigned DATA_W    = 32,
  parameter bit          INCLUDE_T = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dump_req,
  input  logic [DATA_W-1:0] pc_in,
  output logic              stall_req,
  output logic [4:0]        dbg_rd_addr,
  input  logic [DATA_W-1:0] dbg_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_tag,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned NumRegs = INCLUDE_T ? 12 : 8;
  localparam logic [3:0]  LastIdx = 4'(NumRegs - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHdr, StFetch, StSend, StCsum} state_t;
`else
  typedef enum logic [2:0] {StIdle, StHdr, StFetch, StSend} state_t;
`endif

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_hold;
  logic [4:0]        w_reg_addr;
  logic              w_last_reg;

  // idx 0..7 -> r16..r23 ($s0-$s7), idx 8..11 -> r8..r11 ($t0-$t3)
  assign w_reg_addr = r_idx[3] ? {1'b0, r_idx} : {2'b10, r_idx[2:0]};
  assign w_last_reg = (r_idx == LastIdx);

  assign busy      = (r_state != StIdle);
  assign stall_req = busy;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  // Cleared on header entry, then folds in every accepted PC/register word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else if (r_state == StIdle && dump_req) begin
      r_csum <= '0;
    end else if ((r_state == StHdr || r_state == StSend) && out_ready) begin
      r_csum <= r_csum ^ out_data;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_pc    <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == StIdle && dump_req) begin
        r_pc <= pc_in;
      end
      if (r_state == StFetch) begin
        r_hold <= dbg_rd_data;
      end
    end
  end

  // Outputs depend only on state and held registers, so they stay stable
  // under backpressure and clear immediately with an asynchronous reset.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    out_valid   = 1'b0;
    out_data    = '0;
    out_tag     = '0;
    out_last    = 1'b0;
    dbg_rd_addr = '0;
    unique case (r_state)
      StIdle: begin
        if (dump_req) begin
          w_state_nxt = StHdr;
        end
      end
      StHdr: begin
        out_valid = 1'b1;
        out_data  = r_pc;
        out_tag   = 6'h20;
        if (out_ready) begin
          w_state_nxt = StFetch;
          w_idx_nxt   = '0;
        end
      end
      StFetch: begin
        dbg_rd_addr = w_reg_addr;
        w_state_nxt = StSend;
      end
      StSend: begin
        out_valid = 1'b1;
        out_data  = r_hold;
        out_tag   = {1'b0, w_reg_addr};
`ifndef REG_DUMP_CHECKSUM_EN
        out_last  = w_last_reg;
`endif
        if (out_ready) begin
          if (w_last_reg) begin
            w_idx_nxt   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
            w_state_nxt = StCsum;
`else
            w_state_nxt = StIdle;
`endif
          end else begin
            w_idx_nxt   = r_idx + 4'd1;
            w_state_nxt = StFetch;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      StCsum: begin
        out_valid = 1'b1;
        out_data  = r_csum;
        out_tag   = 6'h3F;
        out_last  = 1'b1;
        if (out_ready) begin
          w_state_nxt = StIdle;
        end
      end
`endif
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: two instances (INCLUDE_T=1 and INCLUDE_T=0) share a
// behavioural register file. Expected frames are built from the register order
// and register contents; a per-cycle monitor compares accepted words and
// checks stream stability under backpressure.
module tb_reg_dump_tx;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  localparam int Edges12 = 1 + 2 * 12 + CSUM;
  localparam int Edges8  = 1 + 2 * 8 + CSUM;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clock, reset_n;
  logic [31:0] pc_in;
  logic [31:0] rf [32];

  // INCLUDE_T=1 instance
  logic        dump_req, stall_req, out_valid, out_ready, out_last, busy;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] dbg_rd_data, out_data;
  logic [5:0]  out_tag;
  // INCLUDE_T=0 instance
  logic        dump_req0, stall_req0, out_valid0, out_ready0, out_last0, busy0;
  logic [4:0]  dbg_rd_addr0;
  logic [31:0] dbg_rd_data0, out_data0;
  logic [5:0]  out_tag0;

  assign dbg_rd_data  = rf[dbg_rd_addr];
  assign dbg_rd_data0 = rf[dbg_rd_addr0];

  reg_dump_tx #(.DATA_W(32), .INCLUDE_T(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .dump_req(dump_req), .pc_in(pc_in),
    .stall_req(stall_req), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_last(out_last), .busy(busy)
  );

  reg_dump_tx #(.DATA_W(32), .INCLUDE_T(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .dump_req(dump_req0), .pc_in(pc_in),
    .stall_req(stall_req0), .dbg_rd_addr(dbg_rd_addr0), .dbg_rd_data(dbg_rd_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_tag(out_tag0), .out_last(out_last0), .busy(busy0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    errors = 0;
  int    checks = 0;
  int    edges  = 0;
  beat_t exp_q[$];
  beat_t exp0_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame model: header, registers in dump order, optional XOR checksum.
  function automatic void build_frame(input logic [31:0] pc, input bit inc_t);
    int    order[$];
    beat_t b;
    logic [31:0] x;
    for (int r = 16; r <= 23; r++) order.push_back(r);
    if (inc_t) for (int r = 8; r <= 11; r++) order.push_back(r);
    b.tag = 6'h20; b.data = pc; b.last = 1'b0;
    x = pc;
    if (inc_t) exp_q.push_back(b); else exp0_q.push_back(b);
    for (int i = 0; i < order.size(); i++) begin
      b.tag  = 6'(order[i]);
      b.data = rf[order[i]];
      b.last = (i == order.size() - 1) && (CSUM == 0);
      x      = x ^ b.data;
      if (inc_t) exp_q.push_back(b); else exp0_q.push_back(b);
    end
    if (CSUM != 0) begin
      b.tag = 6'h3F; b.data = x; b.last = 1'b1;
      if (inc_t) exp_q.push_back(b); else exp0_q.push_back(b);
    end
  endfunction

  // Per-cycle monitor for both instances, sampled on the falling edge.
  initial begin
    logic        hold_p;
    logic [31:0] data_p;
    logic [5:0]  tag_p;
    logic        last_p;
    beat_t       b;
    hold_p = 1'b0;
    data_p = '0;
    tag_p  = '0;
    last_p = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        hold_p = 1'b0;
      end else begin
        check("stall_eq_busy", 64'(stall_req), 64'(busy));
        if (out_valid) check("addr_zero_when_valid", 64'(dbg_rd_addr), 64'(0));
        if (hold_p) begin
          check("held_valid", 64'(out_valid), 64'(1));
          check("held_data", 64'(out_data), 64'(data_p));
          check("held_tag", 64'(out_tag), 64'(tag_p));
          check("held_last", 64'(out_last), 64'(last_p));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tag 0x%0h data 0x%0h, expected no word",
                     out_tag, out_data);
          end else begin
            b = exp_q.pop_front();
            check("beat_tag", 64'(out_tag), 64'(b.tag));
            check("beat_data", 64'(out_data), 64'(b.data));
            check("beat_last", 64'(out_last), 64'(b.last));
          end
        end
        hold_p = out_valid && !out_ready;
        data_p = out_data;
        tag_p  = out_tag;
        last_p = out_last;
        if (out_valid0) begin
          if (exp0_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat0: got tag 0x%0h, expected no word", out_tag0);
          end else begin
            b = exp0_q.pop_front();
            check("beat0_tag", 64'(out_tag0), 64'(b.tag));
            check("beat0_data", 64'(out_data0), 64'(b.data));
            check("beat0_last", 64'(out_last0), 64'(b.last));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    edges++;
  endtask

  // Pulse dump_req for one edge; edges then counts from the request edge.
  task automatic start_req();
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    edges = 0;
    check("busy_after_req", 64'(busy), 64'(1));
  endtask

  task automatic wait_tag(input logic [5:0] tag);
    int n = 0;
    while (!(out_valid && out_tag == tag) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_tag: got no word with tag 0x%0h, expected one within 100 cycles", tag);
    end
  endtask

  task automatic finish_frame(input string name, input int exp_edges, input int remain);
    while (busy && edges < 200) step();
    check({name, "_edges"}, 64'(edges), 64'(exp_edges));
    check({name, "_drained"}, 64'(exp_q.size()), 64'(remain));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n    = 1'b0;
    dump_req   = 1'b0;
    dump_req0  = 1'b0;
    out_ready  = 1'b1;
    out_ready0 = 1'b1;
    pc_in      = 32'h0000_0040;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | 32'(i);
    for (int i = 0; i < 8; i++) rf[16 + i] = 32'h10 + 32'(i);
    for (int i = 0; i < 4; i++) rf[8 + i] = 32'h80 + 32'(i);

    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_tag", 64'(out_tag), 64'(0));
    check("rst_last", 64'(out_last), 64'(0));
    check("rst_stall", 64'(stall_req), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_addr", 64'(dbg_rd_addr), 64'(0));
    reset_n = 1'b1;
    step();

    // Pin the model against hand-computed words.
    build_frame(32'h40, 1'b1);
    check("model_len", 64'(exp_q.size()), 64'(13 + CSUM));
    check("model_hdr", 64'(exp_q[0]), 64'({6'h20, 32'h40, 1'b0}));
    check("model_r16", 64'(exp_q[1]), 64'({6'h10, 32'h10, 1'b0}));
    check("model_r11", 64'(exp_q[12]), 64'({6'h0B, 32'h83, (CSUM == 0)}));
`ifdef REG_DUMP_CHECKSUM_EN
    check("model_csum", 64'(exp_q[13]), 64'({6'h3F, 32'h40, 1'b1}));
`endif

    // Basic frame, no backpressure.
    start_req();
    finish_frame("basic", Edges12, 0);

    // Backpressure on the header and on idx 5 (r21).
    pc_in = 32'h1234_5678;
    build_frame(pc_in, 1'b1);
    start_req();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    wait_tag(6'h15);
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    finish_frame("bp", Edges12 + 6, 0);

    // Request during idx 2 is ignored.
    build_frame(pc_in, 1'b1);
    start_req();
    wait_tag(6'h12);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    finish_frame("ignored", Edges12, 0);
    n = 0;
    repeat (4) begin
      step();
      if (busy) n++;
    end
    check("ignored_busy_cycles", 64'(n), 64'(0));

    // Request held high: back-to-back frames.
    pc_in = 32'h0000_0040;
    build_frame(pc_in, 1'b1);
    build_frame(pc_in, 1'b1);
    dump_req = 1'b1;
    step();
    edges = 0;
    finish_frame("held1", Edges12, 13 + CSUM);
    check("held_idle_gap", 64'(busy), 64'(0));
    step();
    edges = 0;
    dump_req = 1'b0;
    check("held_restart", 64'(busy), 64'(1));
    finish_frame("held2", Edges12, 0);

    // Asynchronous reset while SEND of idx 3 (r19).
    build_frame(pc_in, 1'b1);
    start_req();
    wait_tag(6'h13);
    #1;
    reset_n = 1'b0;
    #1;
    check("amid_valid", 64'(out_valid), 64'(0));
    check("amid_stall", 64'(stall_req), 64'(0));
    check("amid_busy", 64'(busy), 64'(0));
    check("amid_last", 64'(out_last), 64'(0));
    exp_q.delete();
    repeat (2) step();
    reset_n = 1'b1;
    step();
    build_frame(pc_in, 1'b1);
    start_req();
    finish_frame("post_rst", Edges12, 0);

    // INCLUDE_T=0 instance.
    build_frame(pc_in, 1'b0);
    check("model0_len", 64'(exp0_q.size()), 64'(9 + CSUM));
    check("model0_r23", 64'(exp0_q[8]), 64'({6'h17, 32'h17, (CSUM == 0)}));
    dump_req0 = 1'b1;
    step();
    dump_req0 = 1'b0;
    n = 0;
    while (busy0 && n < 200) begin
      step();
      n++;
    end
    check("t0_edges", 64'(n), 64'(Edges8));
    check("t0_drained", 64'(exp0_q.size()), 64'(0));

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
